gate_checker: RTL

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker_pkg.sv | 36 +++
 rtl/gate_checker_expect.sv | 26 ++
 rtl/gate_checker.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the gate-array checker: FSM states, last
// vector index, gate output bit positions and the stimulus pattern helper.
package gate_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [1:0] VEC_LAST = 2'd3;

  localparam int unsigned BIT_AND  = 0;
  localparam int unsigned BIT_OR   = 1;
  localparam int unsigned BIT_NAND = 2;
  localparam int unsigned BIT_NOR  = 3;
  localparam int unsigned BIT_XOR  = 4;
  localparam int unsigned BIT_XNOR = 5;
  localparam int unsigned BIT_BUF  = 6;
  localparam int unsigned BIT_NOT  = 7;

  // a on even bits and b on odd bits of 0..13, a again on 14, bit 15 tied low
  function automatic logic [15:0] vec_pattern(input logic [1:0] vec);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 7; k++) begin
      p[2*k]   = vec[0];
      p[2*k+1] = vec[1];
    end
    p[14] = vec[0];
    return p;
  endfunction

endpackage

// File: rtl/gate_checker_expect.sv
// Expected gate-array response and compare mask for one (a, b) input pair.
// The buffer output is tri-stated when b=0, so that bit is excluded then.
module gate_expect
  import gate_checker_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [7:0] exp,
  output logic [7:0] mask
);

  always_comb begin
    exp            = '0;
    exp[BIT_AND]   = a & b;
    exp[BIT_OR]    = a | b;
    exp[BIT_NAND]  = ~(a & b);
    exp[BIT_NOR]   = ~(a | b);
    exp[BIT_XOR]   = a ^ b;
    exp[BIT_XNOR]  = ~(a ^ b);
    exp[BIT_BUF]   = a;
    exp[BIT_NOT]   = ~a;
    mask           = '1;
    mask[BIT_BUF]  = b;
  end

endmodule

// File: rtl/gate_checker.sv
// Sequences four input vectors into a gate array and counts failing responses.
// Optional GATE_CHECKER_FAIL_CAPTURE_EN adds fail_vec/fail_bits first-failure capture.
//
// state | meaning
// IDLE  | waiting for start; dut_in holds the last vector
// APPLY | new vector on dut_in, settle counter loaded
// WAIT  | SETTLE cycles for the gate array to settle
// CHECK | compare dut_out against expectation, advance vector
// DONE  | one-cycle done pulse, pass valid
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] dut_in,
  input  logic [7:0]  dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_count
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic [1:0]  fail_vec,
  output logic [7:0]  fail_bits
`endif
);

  localparam bit         SKIP_WAIT   = (SETTLE == 0);
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [15:0] dut_in_q, dut_in_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  err_q, err_d;
  logic        pass_q, pass_d;
  logic [7:0]  exp, mask, diff;
  logic        vec_fail;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  logic [1:0]  fail_vec_q, fail_vec_d;
  logic [7:0]  fail_bits_q, fail_bits_d;
`endif

  gate_expect u_expect (
    .a    (vec_q[0]),
    .b    (vec_q[1]),
    .exp  (exp),
    .mask (mask)
  );

  assign diff     = (dut_out ^ exp) & mask;
  assign vec_fail = |diff;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    fail_vec_d  = fail_vec_q;
    fail_bits_d = fail_bits_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_APPLY;
          vec_d    = 2'd0;
          dut_in_d = vec_pattern(2'd0);
          err_d    = 3'd0;
          pass_d   = 1'b0;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
          fail_vec_d  = 2'd0;
          fail_bits_d = 8'd0;
`endif
        end
      end
      ST_APPLY: begin
        cnt_d   = SETTLE_LAST;
        state_d = SKIP_WAIT ? ST_CHECK : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CHECK: begin
        if (vec_fail) begin
          err_d = err_q + 3'd1;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
          if (err_q == 3'd0) begin
            fail_vec_d  = vec_q;
            fail_bits_d = diff;
          end
`endif
        end
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d  = ST_APPLY;
          vec_d    = vec_q + 2'd1;
          dut_in_d = vec_pattern(vec_q + 2'd1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= 2'd0;
      dut_in_q <= 16'h0000;
      cnt_q    <= 4'd0;
      err_q    <= 3'd0;
      pass_q   <= 1'b0;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
      fail_vec_q  <= 2'd0;
      fail_bits_q <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
      fail_vec_q  <= fail_vec_d;
      fail_bits_q <= fail_bits_d;
`endif
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
  assign fail_vec  = fail_vec_q;
  assign fail_bits = fail_bits_q;
`endif

endmodule
